// File: rtl/accel_motion_filter_if.sv
// rtl/accel_motion_filter_if.sv - sample/average bus between accelerometer reader, motion filter and consumer
// master drives samples and clear; slave is the filter, which returns averages and motion flags.
interface accel_motion_filter_if;
   logic               filter_clr;
   logic               sample_valid;
   logic signed [15:0] x_in;
   logic signed [15:0] y_in;
   logic signed [15:0] z_in;
   logic signed [15:0] x_avg;
   logic signed [15:0] y_avg;
   logic signed [15:0] z_avg;
   logic               avg_valid;
   logic               x_motion;
   logic               y_motion;
   logic               z_motion;
   logic               window_full;

   modport master (
      output filter_clr, sample_valid, x_in, y_in, z_in,
      input  x_avg, y_avg, z_avg, avg_valid, x_motion, y_motion, z_motion, window_full
   );

   modport slave (
      input  filter_clr, sample_valid, x_in, y_in, z_in,
      output x_avg, y_avg, z_avg, avg_valid, x_motion, y_motion, z_motion, window_full
   );
endinterface

// File: rtl/accel_motion_filter.sv
// rtl/accel_motion_filter.sv - 3-axis moving-average filter with per-axis motion detection
// Stage 1 updates ring buffers and running sums; stage 2 registers averages and motion flags.
module accel_motion_filter #(
   parameter int          DEPTH_LOG2 = 2,
   parameter logic [15:0] THRESH     = 16'd64
) (
   input logic                  clk,
   input logic                  rst,
   accel_motion_filter_if.slave s_if
);
   localparam int                  N        = 1 << DEPTH_LOG2;
   localparam int                  W        = 16 + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2 + 1)'(N);

   logic signed [15:0]    r_buf [3][N];
   logic signed [W-1:0]   r_sum [3];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2:0]   r_fill;
   logic                  r_s2_go;
   logic                  r_have_prev;
   logic signed [15:0]    r_avg [3];
   logic [2:0]            r_motion;
   logic                  r_avg_valid;

   logic signed [15:0]    w_in [3];
   logic signed [W-1:0]   w_sum_next [3];
   logic signed [15:0]    w_avg [3];
   logic signed [16:0]    w_diff [3];
   logic [16:0]           w_mag [3];
   logic [2:0]            w_motion;
   logic                  w_full;

   assign w_in[0] = s_if.x_in;
   assign w_in[1] = s_if.y_in;
   assign w_in[2] = s_if.z_in;
   assign w_full  = (r_fill == FILL_MAX);

   // The sum width holds N full-scale samples, so plain wrapping arithmetic never overflows.
   always_comb begin
      for (int a = 0; a < 3; a++) begin
         w_sum_next[a] = r_sum[a] + W'(w_in[a]) - W'(r_buf[a][r_wr_ptr]);
         w_avg[a]      = 16'(r_sum[a] >>> DEPTH_LOG2);
         w_diff[a]     = {w_avg[a][15], w_avg[a]} - {r_avg[a][15], r_avg[a]};
         w_mag[a]      = w_diff[a][16] ? 17'(-w_diff[a]) : 17'(w_diff[a]);
         w_motion[a]   = r_have_prev && (w_mag[a] > {1'b0, THRESH});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < N; i++) r_buf[a][i] <= '0;
            r_sum[a] <= '0;
            r_avg[a] <= '0;
         end
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_s2_go     <= 1'b0;
         r_have_prev <= 1'b0;
         r_motion    <= '0;
         r_avg_valid <= 1'b0;
      end else if (s_if.filter_clr) begin
         // Clear wins over a coincident sample and also cancels a pending stage-2 update.
         for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < N; i++) r_buf[a][i] <= '0;
            r_sum[a] <= '0;
            r_avg[a] <= '0;
         end
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_s2_go     <= 1'b0;
         r_have_prev <= 1'b0;
         r_motion    <= '0;
         r_avg_valid <= 1'b0;
      end else begin
         r_s2_go     <= s_if.sample_valid;
         r_avg_valid <= 1'b0;
         if (s_if.sample_valid) begin
            for (int a = 0; a < 3; a++) begin
               r_sum[a]           <= w_sum_next[a];
               r_buf[a][r_wr_ptr] <= w_in[a];
            end
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (!w_full) r_fill <= r_fill + 1'b1;
         end
         if (r_s2_go && w_full) begin
            for (int a = 0; a < 3; a++) r_avg[a] <= w_avg[a];
            r_motion    <= w_motion;
            r_have_prev <= 1'b1;
            r_avg_valid <= 1'b1;
         end
      end
   end

   assign s_if.x_avg       = r_avg[0];
   assign s_if.y_avg       = r_avg[1];
   assign s_if.z_avg       = r_avg[2];
   assign s_if.avg_valid   = r_avg_valid;
   assign s_if.x_motion    = r_motion[0];
   assign s_if.y_motion    = r_motion[1];
   assign s_if.z_motion    = r_motion[2];
   assign s_if.window_full = w_full;
endmodule

// File: tb/tb_accel_motion_filter.sv
// tb/tb_accel_motion_filter.sv - directed self-checking bench for accel_motion_filter (N=4, THRESH=64)
// Inputs change and outputs are sampled on the falling clock edge.
module tb_accel_motion_filter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pulse = 0;

   accel_motion_filter_if m_if ();

   accel_motion_filter #(
      .DEPTH_LOG2 (2),
      .THRESH     (16'd64)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .s_if (m_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_avg_valid"}, 32'(m_if.avg_valid), 0);
      chk({tag, "_window_full"}, 32'(m_if.window_full), 0);
      chk({tag, "_x_avg"}, 32'(m_if.x_avg), 0);
      chk({tag, "_y_avg"}, 32'(m_if.y_avg), 0);
      chk({tag, "_x_motion"}, 32'(m_if.x_motion), 0);
   endtask

   task automatic do_clear(input string tag);
      @(negedge clk);
      m_if.filter_clr = 1'b1;
      @(negedge clk);
      m_if.filter_clr = 1'b0;
      chk_zero(tag);
   endtask

   // One strobe; checks no pulse at +1, expected pulse at +2, single-cycle pulse and held flag at +3.
   task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                       input bit ev, input logic signed [15:0] ex, input bit emx);
      @(negedge clk);
      m_if.x_in = x;
      m_if.y_in = y;
      m_if.z_in = 16'sd0;
      m_if.sample_valid = 1'b1;
      @(negedge clk);
      m_if.sample_valid = 1'b0;
      chk("latency_early", 32'(m_if.avg_valid), 0);
      @(negedge clk);
      chk("avg_valid", 32'(m_if.avg_valid), 32'(ev));
      if (ev) begin
         chk("x_avg", 32'(m_if.x_avg), 32'(ex));
         chk("x_motion", 32'(m_if.x_motion), 32'(emx));
         chk("y_motion", 32'(m_if.y_motion), 0);
         chk("z_motion", 32'(m_if.z_motion), 0);
         chk("window_full", 32'(m_if.window_full), 1);
      end
      @(negedge clk);
      chk("pulse_width", 32'(m_if.avg_valid), 0);
      if (ev) chk("motion_hold", 32'(m_if.x_motion), 32'(emx));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      m_if.filter_clr   = 1'b0;
      m_if.sample_valid = 1'b0;
      m_if.x_in         = 16'sd0;
      m_if.y_in         = 16'sd0;
      m_if.z_in         = 16'sd0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;

      // Fill and wrap-around.
      send(16'sd100, 16'sd10, 1'b0, 16'sd0, 1'b0);
      send(16'sd200, 16'sd20, 1'b0, 16'sd0, 1'b0);
      send(16'sd300, 16'sd30, 1'b0, 16'sd0, 1'b0);
      chk("fill3_window_full", 32'(m_if.window_full), 0);
      send(16'sd400, 16'sd40, 1'b1, 16'sd250, 1'b0);
      chk("fill4_y_avg", 32'(m_if.y_avg), 25);
      send(16'sd500, 16'sd50, 1'b1, 16'sd350, 1'b1);
      send(16'sd600, 16'sd50, 1'b1, 16'sd450, 1'b1);
      send(16'sd700, 16'sd50, 1'b1, 16'sd550, 1'b1);
      send(16'sd800, 16'sd50, 1'b1, 16'sd650, 1'b1);
      send(16'sd0,   16'sd50, 1'b1, 16'sd525, 1'b1);
      chk("wrap_y_avg", 32'(m_if.y_avg), 50);

      // Negative rounding and full-scale negative window.
      do_clear("clear1");
      send(-16'sd3, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(-16'sd3, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(-16'sd3, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(-16'sd3, 16'sd0, 1'b1, -16'sd3, 1'b0);
      send(-16'sd2, 16'sd0, 1'b1, -16'sd3, 1'b0);
      send(-16'sd32768, 16'sd0, 1'b1, -16'sd8194, 1'b1);
      send(-16'sd32768, 16'sd0, 1'b1, -16'sd16386, 1'b1);
      send(-16'sd32768, 16'sd0, 1'b1, -16'sd24577, 1'b1);
      send(-16'sd32768, 16'sd0, 1'b1, -16'sd32768, 1'b1);

      // Motion threshold: steps of 20 stay quiet, 80 trips, exactly 64 does not, 65 does.
      do_clear("clear2");
      repeat (3) send(16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd0, 16'sd0, 1'b1, 16'sd0, 1'b0);
      send(16'sd80, 16'sd0, 1'b1, 16'sd20, 1'b0);
      send(16'sd80, 16'sd0, 1'b1, 16'sd40, 1'b0);
      send(16'sd80, 16'sd0, 1'b1, 16'sd60, 1'b0);
      send(16'sd80, 16'sd0, 1'b1, 16'sd80, 1'b0);
      send(16'sd400, 16'sd0, 1'b1, 16'sd160, 1'b1);
      send(16'sd336, 16'sd0, 1'b1, 16'sd224, 1'b0);
      send(16'sd340, 16'sd0, 1'b1, 16'sd289, 1'b1);

      // Ten back-to-back strobes, then a clear coincident with a strobe.
      do_clear("clear3");
      n_pulse = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_if.avg_valid) n_pulse++;
         m_if.x_in = 16'(4 * (i + 1));
         m_if.y_in = 16'sd0;
         m_if.sample_valid = 1'b1;
      end
      @(negedge clk);
      if (m_if.avg_valid) n_pulse++;
      m_if.sample_valid = 1'b0;
      @(negedge clk);
      if (m_if.avg_valid) n_pulse++;
      chk("b2b_last_avg", 32'(m_if.x_avg), 34);
      m_if.x_in = 16'sd9999;
      m_if.sample_valid = 1'b1;
      m_if.filter_clr = 1'b1;
      @(negedge clk);
      m_if.sample_valid = 1'b0;
      m_if.filter_clr = 1'b0;
      chk("b2b_pulses", n_pulse, 7);
      chk_zero("b2b_clear");
      send(16'sd12, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd24, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd36, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd48, 16'sd0, 1'b1, 16'sd30, 1'b0);

      // Reset one cycle after a strobe kills the pending update.
      send(16'sd40, 16'sd0, 1'b1, 16'sd37, 1'b0);
      send(16'sd40, 16'sd0, 1'b1, 16'sd41, 1'b0);
      send(16'sd40, 16'sd0, 1'b1, 16'sd42, 1'b0);
      @(negedge clk);
      m_if.x_in = 16'sd40;
      m_if.sample_valid = 1'b1;
      @(negedge clk);
      m_if.sample_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_zero("rst_async");
      @(negedge clk);
      rst = 1'b1;
      chk("rst_no_pulse", 32'(m_if.avg_valid), 0);
      n_pulse = 0;
      repeat (3) begin
         @(negedge clk);
         if (m_if.avg_valid) n_pulse++;
      end
      chk("rst_quiet_pulses", n_pulse, 0);
      send(16'sd8, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd8, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd8, 16'sd0, 1'b0, 16'sd0, 1'b0);
      send(16'sd8, 16'sd0, 1'b1, 16'sd8, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/accel_motion_filter.md
ACCEL_MOTION_FILTER -- requirements
Module: accel_motion_filter

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 2, setting the averaging window N = 2^DEPTH_LOG2 samples (legal range 1..4).
REQ-002 The block SHALL have parameter THRESH, default 16'd64, setting the unsigned motion threshold in LSBs of the averaged value.
REQ-003 clk  in  1  the single system clock (100 MHz); all state SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset; asynchronous assert, active-low, synchronously released by the integrating top.
REQ-005 filter_clr  in  1  synchronous, active-high clear of window contents; the block SHALL NOT clear its configuration.
REQ-006 sample_valid  in  1  single-cycle strobe; x_in/y_in/z_in SHALL be taken when high.
REQ-007 x_in, y_in, z_in  in  16 each  signed two's-complement axis samples from the accelerometer reader.
REQ-008 x_avg, y_avg, z_avg  out  16 each  signed windowed averages.
REQ-009 avg_valid  out  1  one-cycle pulse marking new x_avg/y_avg/z_avg and motion flags.
REQ-010 x_motion, y_motion, z_motion  out  1 each  per-axis motion flags, held between avg_valid pulses.
REQ-011 window_full  out  1  high once N samples have been accepted since the last reset or clear.

Function
REQ-012 The block SHALL keep, per axis, an N-entry sample ring buffer, a shared write pointer of DEPTH_LOG2 bits, and a signed running sum of 16+DEPTH_LOG2 bits.
REQ-013 On an edge with sample_valid=1 and filter_clr=0: sum <= sum + new - buf[wr_ptr]; buf[wr_ptr] <= new; wr_ptr <= wr_ptr+1, wrapping from N-1 to 0.
REQ-014 The sum SHALL never overflow: the width of 16+DEPTH_LOG2 bits covers N full-scale samples, and no saturation logic SHALL exist.
REQ-015 A fill counter SHALL increment per accepted sample and saturate at N; window_full SHALL be high when the count equals N.
REQ-016 Stage 2 SHALL fire on the edge after an accepted sample: it SHALL register avg = sum >>> DEPTH_LOG2 (arithmetic shift, rounding toward negative infinity), truncated to 16 bits.
REQ-017 avg_valid SHALL pulse for exactly one cycle, in the cycle following the stage-2 edge, and only if window_full was true after the accepted sample (the first N-1 samples SHALL produce no pulse).
REQ-018 End-to-end latency SHALL be 2 clocks: sample_valid sampled at edge k gives avg_valid high between edge k+1 and edge k+2.
REQ-019 Motion: at each stage-2 update, axis_motion SHALL be set to (|avg_new - avg_prev| > THRESH), using a 17-bit signed difference and its magnitude.
REQ-020 avg_prev SHALL be the previously output average; on the first valid output after reset or clear, all motion flags SHALL be 0.
REQ-021 Motion flags SHALL hold their value until the next avg_valid pulse.
REQ-022 sample_valid on every consecutive cycle SHALL be accepted with no dropped samples and one avg_valid per sample once full.
REQ-023 filter_clr=1 SHALL take priority over a simultaneous sample_valid: the sample SHALL be dropped.
REQ-024 filter_clr=1 SHALL zero the buffers, sums, wr_ptr, fill count, avg_prev, all outputs, and any in-flight stage-2 update.
REQ-025 Ring-buffer entries SHALL be zero after a clear, so sum = (sum of accepted samples) during fill.

Reset
REQ-026 While rst=0, every register SHALL be zero: buffers, sums, wr_ptr, fill count, x/y/z_avg = 0, avg_valid = 0, motion flags = 0, window_full = 0.
REQ-027 Asserting rst mid-operation, including during the stage-2 cycle, SHALL abort immediately with no avg_valid pulse after release until N new samples arrive.

Verification
REQ-028 Fill with N=4: samples x = 100, 200, 300, 400 -> no avg_valid on the first three; after the fourth, x_avg = 250, avg_valid pulses once, 2 clocks after the strobe, and window_full = 1.
REQ-029 Wrap-around: continue with x = 500 -> x_avg = 350; the buffer entry holding 100 is replaced and wr_ptr returns to 0 after 8 samples.
REQ-030 Negative rounding: four samples of x = -3 then one of -2 -> x_avg = -3, then -3 ((-11)>>>2 = -3); four samples of -32768 -> x_avg = -32768 with no overflow.
REQ-031 Motion: steady x = 0 window, then four samples of x = 80 (THRESH = 64) -> x_motion stays 0 until |x_avg delta| > 64; jumps of 20/40/60/80 from average 0 assert x_motion only on the update where the delta exceeds 64; y_motion and z_motion stay 0.
REQ-032 Back-to-back sample_valid for 10 cycles, then filter_clr coincident with a strobe -> 7 avg_valid pulses, the last sample is dropped, and all outputs are 0 the cycle after the clear.
REQ-033 rst pulsed low one cycle after the 4th sample strobe -> no avg_valid pulse; outputs are 0; 4 fresh samples are needed for the next pulse.
